// File: rtl/dac_multi_ctrl.sv
// Multi-channel parallel DAC write sequencer: per-channel setpoints with dirty
// tracking, timed CS/WR strobe sweeps and an optional simultaneous LDAC update.
module dac_multi_ctrl #(
    parameter int DW      = 8,
    parameter int NCH     = 2,
    parameter int T_GAP   = 200,
    parameter int T_SETUP = 4,
    parameter int T_WR    = 50,
    parameter int T_HOLD  = 30,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_ch,
    input  logic [DW-1:0] cmd_val,
    input  logic          sat_en,
    input  logic          sync_mode,
    output logic          dac_csn,
    output logic          dac_wrn,
    output logic          dac_ldacn,
    output logic [CW-1:0] dac_addr,
    output logic [DW-1:0] dac_d,
    output logic          busy,
    output logic          sweep_done,
    output logic          sat_hit
);
    localparam int PW    = CW + 1;
    localparam int T_M1  = (T_GAP > T_SETUP) ? T_GAP : T_SETUP;
    localparam int T_M2  = (T_WR > T_HOLD) ? T_WR : T_HOLD;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int CNTW  = $clog2(T_MAX + 1);

    localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(T_GAP - 1);
    localparam logic [CNTW-1:0] SETUP_LAST = CNTW'(T_SETUP - 1);
    localparam logic [CNTW-1:0] WR_LAST    = CNTW'(T_WR - 1);
    localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(T_HOLD - 1);
    localparam logic [PW-1:0]   NCH_P      = PW'(NCH);

    typedef enum logic [2:0] {
        ST_GAP    = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETUP  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_LATCH  = 3'd5
    } state_e;

    // Returns {clamped, result}; the clamp flag is only raised when sat is set.
    function automatic logic [DW:0] arith(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic sat);
        logic [DW:0] ext;
        logic [DW:0] res;
        ext = '0;
        res = {1'b0, a};
        case (op)
            2'b00: res = {1'b0, b};
            2'b01: begin
                ext = {1'b0, a} + {1'b0, b};
                res = (ext[DW] && sat) ? {1'b1, {DW{1'b1}}} : {1'b0, ext[DW-1:0]};
            end
            2'b10: begin
                ext = {1'b0, a} - {1'b0, b};
                res = (ext[DW] && sat) ? {1'b1, {DW{1'b0}}} : {1'b0, ext[DW-1:0]};
            end
            default: res = {1'b0, a};
        endcase
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wrote_q, wrote_d;
    logic [DW-1:0]   sp_q [NCH];
    logic [DW-1:0]   sp_d [NCH];
    logic [NCH-1:0]  dirty_q, dirty_d;
    logic [CW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            csn_q, csn_d, wrn_q, wrn_d, ldacn_q, ldacn_d;
    logic            busy_q, busy_d, done_q, done_d, sat_q, sat_d, ready_q;

    logic            cmd_acc_s;
    logic [DW:0]     op_res_s;
    logic            sel_found_s;
    logic [CW-1:0]   sel_ch_s;
    logic            latch_s;

    // Command acceptance and the arithmetic result for the addressed channel.
    always_comb begin
        cmd_acc_s = cmd_valid && ready_q && (cmd_op != 2'b11) && ({1'b0, cmd_ch} < NCH_P);
        op_res_s  = arith(cmd_op, sp_q[cmd_ch], cmd_val, sat_en);
    end

    // Lowest dirty channel at or above the sweep pointer.
    always_comb begin
        sel_found_s = 1'b0;
        sel_ch_s    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            sel_ch_s    = (dirty_q[i] && (PW'(i) >= ptr_q)) ? CW'(i) : sel_ch_s;
            sel_found_s = sel_found_s | (dirty_q[i] && (PW'(i) >= ptr_q));
        end
    end

    // Sweep sequencing: state, phase counter, pointer and written flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNTW'(1);
        ptr_d   = ptr_q;
        wrote_d = wrote_q;
        latch_s = 1'b0;
        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (|dirty_q) ? ST_SELECT : ST_GAP;
                    ptr_d   = '0;
                    wrote_d = 1'b0;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_SELECT: begin
                cnt_d = '0;
                if (sel_found_s) begin
                    state_d = ST_SETUP;
                    latch_s = 1'b1;
                    wrote_d = 1'b1;
                end else if (sync_mode && wrote_q) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SELECT;
                    ptr_d   = {1'b0, addr_q} + PW'(1);
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_LATCH: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    // Setpoints, dirty bits and the latched output bus; a same-cycle command re-dirties.
    always_comb begin
        sp_d    = sp_q;
        dirty_d = dirty_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sat_d   = 1'b0;
        if (latch_s) begin
            addr_d            = sel_ch_s;
            data_d            = sp_q[sel_ch_s];
            dirty_d[sel_ch_s] = 1'b0;
        end else begin
            addr_d = addr_q;
        end
        if (cmd_acc_s) begin
            sp_d[cmd_ch]    = op_res_s[DW-1:0];
            dirty_d[cmd_ch] = 1'b1;
            sat_d           = op_res_s[DW];
        end else begin
            sat_d = 1'b0;
        end
    end

    // Strobe and status levels for the upcoming state.
    always_comb begin
        csn_d   = ~((state_d == ST_SETUP) || (state_d == ST_WRITE) || (state_d == ST_HOLD));
        wrn_d   = ~(state_d == ST_WRITE);
        ldacn_d = (state_d == ST_LATCH) ? 1'b0 : sync_mode;
        busy_d  = (state_d != ST_GAP);
        done_d  = (state_q != ST_GAP) && (state_d == ST_GAP);
    end

    // State and datapath registers; reset marks every channel dirty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            ptr_q   <= '0;
            wrote_q <= 1'b0;
            for (int i = 0; i < NCH; i++) sp_q[i] <= '0;
            dirty_q <= '1;
            addr_q  <= '0;
            data_q  <= '0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            ldacn_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wrote_q <= wrote_d;
            for (int i = 0; i < NCH; i++) sp_q[i] <= sp_d[i];
            dirty_q <= dirty_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            ldacn_q <= ldacn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            ready_q <= 1'b1;
        end
    end

    assign cmd_ready  = ready_q;
    assign dac_csn    = csn_q;
    assign dac_wrn    = wrn_q;
    assign dac_ldacn  = ldacn_q;
    assign dac_addr   = addr_q;
    assign dac_d      = data_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign sat_hit    = sat_q;

endmodule

// File: tb/tb_dac_multi_ctrl.sv
// Self-checking bench for dac_multi_ctrl: a sequential timeline model predicts
// every output each cycle; directed phases pin the model with literal values.
module tb_dac_multi_ctrl;
    localparam int DW = 8, NCH = 2, CW = 1;
    localparam int T_GAP = 200, T_SETUP = 4, T_WR = 50, T_HOLD = 30;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    logic rst, cmd_valid, sat_en, sync_mode;
    logic [1:0] cmd_op;
    logic [CW-1:0] cmd_ch;
    logic [DW-1:0] cmd_val;
    logic cmd_ready, dac_csn, dac_wrn, dac_ldacn, busy, sweep_done, sat_hit;
    logic [CW-1:0] dac_addr;
    logic [DW-1:0] dac_d;

    always #5 clk = ~clk;

    dac_multi_ctrl #(.DW(DW), .NCH(NCH), .T_GAP(T_GAP), .T_SETUP(T_SETUP),
                     .T_WR(T_WR), .T_HOLD(T_HOLD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_val(cmd_val), .sat_en(sat_en),
        .sync_mode(sync_mode), .dac_csn(dac_csn), .dac_wrn(dac_wrn),
        .dac_ldacn(dac_ldacn), .dac_addr(dac_addr), .dac_d(dac_d), .busy(busy),
        .sweep_done(sweep_done), .sat_hit(sat_hit));

    int n_cmp = 0, n_bad = 0, n_print = 0;

    // ---------------- behavioural model ----------------
    int m_sp [NCH];
    bit m_dirty [NCH];
    bit m_ready, ab;
    bit e_ready, e_csn, e_wrn, e_ldacn, e_busy, e_done, e_sat;
    logic [CW-1:0] e_addr;
    logic [DW-1:0] e_d;

    task automatic reset_model();
        for (int i = 0; i < NCH; i++) begin m_sp[i] = 0; m_dirty[i] = 1'b1; end
        m_ready = 1'b0;
        e_ready = 1'b0; e_csn = 1'b1; e_wrn = 1'b1; e_ldacn = 1'b1;
        e_busy = 1'b0; e_done = 1'b0; e_sat = 1'b0; e_addr = '0; e_d = '0;
    endtask

    task automatic edge_wait();
        if (!ab) begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) ab = 1'b1;
        end
    endtask

    // Effects of one clock edge; the arguments describe the cycle that follows it.
    task automatic apply(input bit csn, input bit wrn, input bit lat, input bit bz,
                         input bit dn, input int lch);
        int c, r;
        if (ab) return;
        if (lch >= 0) begin
            e_d = DW'(m_sp[lch]); e_addr = CW'(lch); m_dirty[lch] = 1'b0;
        end
        e_sat = 1'b0;
        c = int'(cmd_ch);
        if (m_ready && cmd_valid && cmd_op != 2'b11 && c < NCH) begin
            r = m_sp[c];
            if (cmd_op == 2'b00) r = int'(cmd_val);
            else if (cmd_op == 2'b01) begin
                r = m_sp[c] + int'(cmd_val);
                if (r > MAXV) begin
                    if (sat_en) begin r = MAXV; e_sat = 1'b1; end
                    else r = r - (MAXV + 1);
                end
            end else begin
                r = m_sp[c] - int'(cmd_val);
                if (r < 0) begin
                    if (sat_en) begin r = 0; e_sat = 1'b1; end
                    else r = r + (MAXV + 1);
                end
            end
            m_sp[c] = r;
            m_dirty[c] = 1'b1;
        end
        m_ready = 1'b1; e_ready = 1'b1;
        e_csn = csn; e_wrn = wrn; e_busy = bz; e_done = dn;
        e_ldacn = lat ? 1'b0 : sync_mode;
    endtask

    task automatic step(input bit csn, input bit wrn, input bit lat, input bit bz,
                        input bit dn, input int lch);
        edge_wait();
        apply(csn, wrn, lat, bz, dn, lch);
    endtask

    function automatic int pick(input int ptr);
        for (int i = 0; i < NCH; i++) if (m_dirty[i] && i >= ptr) return i;
        return -1;
    endfunction

    function automatic bit any_dirty();
        for (int i = 0; i < NCH; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Timeline: gap, then one write per dirty channel, then optional LDAC pulse.
    task automatic run_model();
        int ch, ptr;
        bit wrote;
        forever begin
            for (int i = 1; i < T_GAP; i++) step(1, 1, 0, 0, 0, -1);
            if (ab) return;
            if (!any_dirty()) step(1, 1, 0, 0, 0, -1);
            else begin
                ptr = 0; wrote = 1'b0;
                step(1, 1, 0, 1, 0, -1);
                forever begin
                    if (ab) return;
                    ch = pick(ptr);
                    if (ch < 0) break;
                    step(0, 1, 0, 1, 0, ch);
                    wrote = 1'b1;
                    for (int i = 1; i < T_SETUP; i++) step(0, 1, 0, 1, 0, -1);
                    for (int i = 0; i < T_WR; i++) step(0, 0, 0, 1, 0, -1);
                    for (int i = 0; i < T_HOLD; i++) step(0, 1, 0, 1, 0, -1);
                    ptr = ch + 1;
                    step(1, 1, 0, 1, 0, -1);
                end
                edge_wait();
                if (ab) return;
                if (sync_mode && wrote) begin
                    apply(1, 1, 1, 1, 0, -1);
                    for (int i = 1; i < T_WR; i++) step(1, 1, 1, 1, 0, -1);
                    step(1, 1, 0, 0, 1, -1);
                end else apply(1, 1, 0, 0, 1, -1);
            end
            if (ab) return;
        end
    endtask

    initial begin
        #2;
        forever begin
            reset_model();
            wait (rst === 1'b1);
            ab = 1'b0;
            run_model();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [7+CW+DW-1:0] act, exp;
        act = {cmd_ready, dac_csn, dac_wrn, dac_ldacn, busy, sweep_done, sat_hit, dac_addr, dac_d};
        exp = {e_ready, e_csn, e_wrn, e_ldacn, e_busy, e_done, e_sat, e_addr, e_d};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_print < 30) begin
                n_print++;
                $display("FAIL outputs t=%0t act=%h exp=%h (rdy csn wrn ldac busy done sat addr d)",
                         $time, act, exp);
            end
        end
    end

    // ---------------- write / ldac monitor ----------------
    typedef struct { int addr; int d; int csn_len; int wrn_len; } wr_t;
    wr_t wq[$];
    int lq[$];
    int sat_cnt = 0, csn_run = 0, wrn_run = 0, ldac_run = 0, cur_addr = 0, cur_d = 0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            csn_run = 0; wrn_run = 0; ldac_run = 0;
        end else begin
            if (!dac_csn) begin
                csn_run++; if (!dac_wrn) wrn_run++;
                cur_addr = int'(dac_addr); cur_d = int'(dac_d);
            end else if (csn_run > 0) begin
                wq.push_back('{cur_addr, cur_d, csn_run, wrn_run});
                csn_run = 0; wrn_run = 0;
            end
            if (!dac_ldacn) ldac_run++;
            else if (ldac_run > 0) begin lq.push_back(ldac_run); ldac_run = 0; end
            if (sat_hit) sat_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input int idx, input int a, input int d);
        if (idx >= wq.size()) chk({nm, "_present"}, wq.size(), idx + 1);
        else begin
            chk({nm, "_addr"}, wq[idx].addr, a);
            chk({nm, "_data"}, wq[idx].d, d);
            chk({nm, "_csn_len"}, wq[idx].csn_len, 84);
            chk({nm, "_wrn_len"}, wq[idx].wrn_len, 50);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input int ch, input int v);
        cmd_valid = 1'b1; cmd_op = op; cmd_ch = CW'(ch); cmd_val = DW'(v);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (sweep_done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) chk({tag, "_done_timeout"}, k, 0);
        @(negedge clk); #1;
    endtask

    task automatic wait_wrn_low(input string tag, input int exp_k);
        int k = 0;
        while (dac_wrn !== 1'b0 && k < 3000) begin @(negedge clk); k++; end
        if (exp_k > 0) chk(tag, k, exp_k);
        else if (k >= 3000) chk({tag, "_timeout"}, k, 0);
    endtask

    task automatic power_on_sweep(input string tag);
        wq.delete(); lq.delete();
        wait_wrn_low({tag, "_first_wrn_edge"}, 205);
        wait_done(tag);
        chk({tag, "_nwrites"}, wq.size(), 2);
        chk_wr({tag, "_w0"}, 0, 0, 8'h00);
        chk_wr({tag, "_w1"}, 1, 1, 8'h00);
        chk({tag, "_ldac_low"}, int'(dac_ldacn), 0);
        chk({tag, "_ldac_runs"}, lq.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = '0; cmd_val = '0;
        sat_en = 1'b0; sync_mode = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({cmd_ready, dac_csn, dac_wrn, dac_ldacn, busy, sweep_done,
                                   sat_hit, dac_addr, dac_d}), 32'h7000);
        rst = 1'b1;
        power_on_sweep("por");

        wq.delete();
        cmd(2'b00, 1, 8'hF0);
        wait_done("load_ch1");
        chk("load_ch1_nwrites", wq.size(), 1);
        chk_wr("load_ch1_w", 0, 1, 8'hF0);

        wq.delete(); s0 = sat_cnt; sat_en = 1'b1;
        cmd(2'b00, 0, 8'hFE);
        cmd(2'b01, 0, 5);
        wait_done("sat_add");
        chk("sat_add_pulses", sat_cnt - s0, 1);
        chk_wr("sat_add_w", 0, 0, 8'hFF);

        wq.delete(); s0 = sat_cnt; sat_en = 1'b0;
        cmd(2'b00, 0, 8'h02);
        cmd(2'b10, 0, 3);
        wait_done("wrap_sub");
        chk("wrap_sub_pulses", sat_cnt - s0, 0);
        chk_wr("wrap_sub_w", 0, 0, 8'hFF);

        wq.delete(); sync_mode = 1'b1;
        cmd(2'b00, 0, 8'h33);
        cmd(2'b00, 1, 8'h44);
        lq.delete();
        wait_done("sync");
        chk("sync_nwrites", wq.size(), 2);
        chk_wr("sync_w0", 0, 0, 8'h33);
        chk_wr("sync_w1", 1, 1, 8'h44);
        chk("sync_ldac_runs", lq.size(), 1);
        if (lq.size() > 0) chk("sync_ldac_len", lq[0], 50);

        sync_mode = 1'b0; wq.delete();
        cmd(2'b00, 0, 8'h11);
        k = 0;
        while (busy !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) chk("race_select_timeout", k, 0);
        cmd(2'b00, 0, 8'h22);
        wait_done("race1");
        chk("race1_nwrites", wq.size(), 1);
        chk_wr("race1_w", 0, 0, 8'h11);
        wq.delete();
        wait_done("race2");
        chk_wr("race2_w", 0, 0, 8'h22);

        cmd(2'b00, 1, 8'h55);
        wait_wrn_low("abort_wait", 0);
        #2 rst = 1'b0;
        #1 chk("abort_outputs", int'({cmd_ready, dac_csn, dac_wrn, dac_ldacn, busy, sweep_done,
                                       sat_hit, dac_addr, dac_d}), 32'h7000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        power_on_sweep("abort");

        for (int c = 0; c < 12000; c++) begin
            cmd_valid = ($urandom_range(0, 15) == 0);
            cmd_op = 2'($urandom_range(0, 3));
            cmd_ch = CW'($urandom_range(0, NCH - 1));
            cmd_val = DW'($urandom);
            sat_en = 1'($urandom);
            if ($urandom_range(0, 999) == 0) sync_mode = ~sync_mode;
            if (c == 6000) #2 rst = 1'b0;
            if (c == 6003) rst = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_multi_ctrl.md
DAC_MULTI_CTRL -- requirements
Module: dac_multi_ctrl

Interface
REQ-001 Parameter DW, default 8: DAC data width in bits.
REQ-002 Parameter NCH, default 2: number of DAC channels; CW = max(1, clog2(NCH)).
REQ-003 Parameter T_GAP, default 200: idle cycles between sweeps.
REQ-004 Parameter T_SETUP, default 4: address/data setup cycles before the write strobe.
REQ-005 Parameter T_WR, default 50: cycles for the write strobe and for the load strobe.
REQ-006 Parameter T_HOLD, default 30: address/data hold cycles after the write strobe.
REQ-007 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 Port rst, input, 1: reset, asynchronous, active-low.
REQ-009 Port cmd_valid, input, 1: command present.
REQ-010 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-011 Port cmd_op, input, 2: 00 load, 01 add, 10 subtract, 11 reserved and ignored.
REQ-012 Port cmd_ch, input, CW: target channel.
REQ-013 Port cmd_val, input, DW: operand.
REQ-014 Port sat_en, input, 1: 1 saturates add/subtract results; 0 wraps them.
REQ-015 Port sync_mode, input, 1: 0 transparent load; 1 simultaneous load after each sweep.
REQ-016 Ports dac_csn, dac_wrn and dac_ldacn, output, 1 each: active-low DAC strobes.
REQ-017 Port dac_addr, output, CW: DAC channel select.
REQ-018 Port dac_d, output, DW: DAC data bus.
REQ-019 Port busy, output, 1: high while a sweep is in progress.
REQ-020 Port sweep_done, output, 1: one-cycle pulse at the end of each sweep.
REQ-021 Port sat_hit, output, 1: one-cycle pulse when an accepted add/subtract is clamped.

Function
REQ-022 Each channel SHALL have a DW-bit setpoint register and a dirty bit.
REQ-023 cmd_ready SHALL be 1 in every cycle after reset; an accepted command updates its setpoint on the next edge.
- Load: setpoint = cmd_val.
- Add/subtract: sat_en=1 clamps to 2^DW-1 or 0 and pulses sat_hit; sat_en=0 gives the result modulo 2^DW with no sat_hit.
REQ-024 Any accepted command other than op 11 SHALL set the target channel's dirty bit, even if the value is unchanged.
- A cmd_ch >= NCH SHALL be ignored.
REQ-025 The FSM SHALL have states GAP, SELECT, SETUP, WRITE, HOLD and LATCH; each timed state lasts exactly its parameter in cycles.
REQ-026 GAP: dac_csn=1 and dac_wrn=1.
- At the end of T_GAP, if any dirty bit is set, go to SELECT with the pointer at 0; otherwise restart GAP.
REQ-027 SELECT (1 cycle): choose the lowest dirty channel with index >= pointer and go to SETUP; if there is none, end the sweep.
REQ-028 On SETUP entry the chosen channel's setpoint SHALL be latched onto dac_d and its index onto dac_addr, and its dirty bit SHALL be cleared.
- If a command to the same channel is accepted in that same cycle, the old value is latched and the dirty bit stays set.
REQ-029 Strobe levels by state:
- SETUP: dac_csn=0, dac_wrn=1.
- WRITE: dac_csn=0, dac_wrn=0.
- HOLD: dac_csn=0, dac_wrn=1.
- dac_d and dac_addr SHALL stay constant from SETUP entry to the end of HOLD.
REQ-030 After HOLD the pointer SHALL advance to the chosen index + 1, and the FSM returns to SELECT.
REQ-031 Sweep end:
- sync_mode=1 and at least one channel written: go to LATCH, with dac_ldacn=0 and dac_csn=1 for T_WR cycles, then go to GAP.
- Otherwise: go directly to GAP.
- sweep_done SHALL pulse in the first GAP cycle after a sweep.
REQ-032 When sync_mode=0, dac_ldacn SHALL be held 0; when sync_mode=1, it is 1 outside LATCH.
- sync_mode is sampled at sweep end.
REQ-033 busy SHALL be 1 from SELECT entry until GAP entry.
REQ-034 Internal counters SHALL be wide enough for the largest timing parameter, with no wrap.

Reset
REQ-035 While rst=0 the outputs SHALL be:
- dac_csn=1, dac_wrn=1, dac_ldacn=1.
- dac_addr=0, dac_d=0.
- busy=0, sweep_done=0, sat_hit=0, cmd_ready=0.
REQ-036 While rst=0, setpoints SHALL be 0, all dirty bits SHALL be 1, the pointer SHALL be 0, and the state SHALL be GAP with its counter at 0.
REQ-037 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the first sweep rewrites every channel with 0.

Verification
REQ-038 Release reset, sync_mode=0, no commands:
- After 200 GAP cycles, ch0 then ch1 are written with 0.
- Each write has csn low for 84 cycles and wrn low for 50 cycles.
- dac_ldacn stays 0 throughout; then the FSM idles in GAP.
REQ-039 Load ch1=0xF0 while idle:
- The next sweep writes only ch1: dac_addr=1, dac_d=0xF0.
- ch0 is skipped with no strobe.
REQ-040 sat_en=1, ch0=0xFE, add 5: ch0=0xFF and sat_hit pulses.
- sat_en=0, ch0=0x02, subtract 3: ch0=0xFF and no sat_hit.
REQ-041 sync_mode=1, both channels dirty:
- Two writes occur with dac_ldacn=1.
- Then dac_ldacn=0 for 50 cycles, then sweep_done pulses.
REQ-042 Command to ch0 in its SETUP-entry cycle:
- dac_d carries the old value.
- ch0 is rewritten with the new value in the next sweep.
REQ-043 Assert rst during WRITE:
- The outputs go to their reset values in the same cycle.
- After release the full sequence of REQ-038 repeats.
